// File: rtl/jpeg_dequant_pkg.sv
// Shared constants for JPEG luma dequantization: standard Y table, zigzag map, clamp helper.
package jpeg_dequant_pkg;

  localparam int DEF_IN_W  = 11;
  localparam int DEF_OUT_W = 12;
  localparam int DEF_QT_W  = 8;
  localparam int PROD_W    = DEF_IN_W + DEF_QT_W;

  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((1 <<< (DEF_OUT_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-(1 <<< (DEF_OUT_W - 1)));

  // Standard JPEG luminance quantization table, raster order
  localparam logic [7:0] Y_QTABLE [0:63] = '{
    16,  11,  10,  16,  24,  40,  51,  61,
    12,  12,  14,  19,  26,  58,  60,  55,
    14,  13,  16,  24,  40,  57,  69,  56,
    14,  17,  22,  29,  51,  87,  80,  62,
    18,  22,  37,  56,  68, 109, 103,  77,
    24,  35,  55,  64,  81, 104, 113,  92,
    49,  64,  78,  87, 103, 121, 120, 101,
    72,  92,  95,  98, 112, 100, 103,  99
  };

  localparam logic [5:0] ZIGZAG_TO_RASTER [0:63] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  typedef struct packed {
    logic signed [DEF_OUT_W-1:0] value;
    logic                        sat;
  } sat_result_t;

  function automatic sat_result_t sat_s(input logic signed [PROD_W-1:0] p);
    sat_result_t r;
    r.sat = 1'b1;
    if (p > SAT_MAX) begin
      r.value = {1'b0, {(DEF_OUT_W-1){1'b1}}};
    end else if (p < SAT_MIN) begin
      r.value = {1'b1, {(DEF_OUT_W-1){1'b0}}};
    end else begin
      r.value = p[DEF_OUT_W-1:0];
      r.sat   = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/jpeg_zigzag_lut.sv
// Combinational zigzag stream position to raster index lookup.
module jpeg_zigzag_lut
  import jpeg_dequant_pkg::*;
(
  input  logic [5:0] pos,
  output logic [5:0] raster
);

  assign raster = ZIGZAG_TO_RASTER[pos];

endmodule

// File: rtl/y_dequantizer.sv
// Two-stage streaming luma dequantizer (coef * Q[k], saturated to OUT_W) with 8x8 position tracking.
// Define Y_DEQUANT_ZIGZAG_EN when coefficients arrive in zigzag order instead of raster order.
module y_dequantizer
  import jpeg_dequant_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int QT_W  = DEF_QT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_coef,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_coef,
  output logic [5:0]              out_idx,
  output logic                    out_last,
  output logic                    out_sat
);

  logic                          adv;
  logic                          accept;
  logic [5:0]                    pos;
  logic [5:0]                    map_idx;
  logic                          s1_valid;
  logic signed [IN_W-1:0]        s1_coef;
  logic [QT_W-1:0]               s1_qt;
  logic [5:0]                    s1_idx;
  logic                          s1_last;
  logic signed [IN_W+QT_W-1:0]   prod;
  sat_result_t                   sat_r;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign accept   = in_valid & adv & ~clear;

`ifdef Y_DEQUANT_ZIGZAG_EN
  jpeg_zigzag_lut u_zigzag (
    .pos    (pos),
    .raster (map_idx)
  );
`else
  assign map_idx = pos;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos <= 6'd0;
    end else if (clear) begin
      pos <= 6'd0;
    end else if (accept) begin
      pos <= pos + 6'd1;
    end
  end

  // Stage 1: capture coefficient with its table entry; last keys on stream position, not raster index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_coef  <= '0;
      s1_qt    <= '0;
      s1_idx   <= 6'd0;
      s1_last  <= 1'b0;
    end else if (clear) begin
      s1_valid <= 1'b0;
      s1_coef  <= '0;
      s1_qt    <= '0;
      s1_idx   <= 6'd0;
      s1_last  <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_coef <= in_coef;
        s1_qt   <= Y_QTABLE[map_idx];
        s1_idx  <= map_idx;
        s1_last <= (pos == 6'd63);
      end
    end
  end

  assign prod  = s1_coef * $signed({1'b0, s1_qt});
  assign sat_r = sat_s(prod);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_coef  <= '0;
      out_idx   <= 6'd0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_coef  <= '0;
      out_idx   <= 6'd0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_coef <= sat_r.value;
        out_idx  <= s1_idx;
        out_last <= s1_last;
        out_sat  <= sat_r.sat;
      end
    end
  end

endmodule

// File: tb/tb_y_dequantizer.sv
// Randomized self-checking bench for y_dequantizer against an arithmetic reference model.
module tb_y_dequantizer;

  localparam int IN_W  = 11;
  localparam int OUT_W = 12;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    clear;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_coef;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_coef;
  logic [5:0]              out_idx;
  logic                    out_last;
  logic                    out_sat;

  y_dequantizer dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coef   (in_coef),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coef  (out_coef),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int coef;
    int idx;
    bit last;
    bit sat;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   tb_pos = 0;
  int   zz[64];
  int   qtab[64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,   12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,   14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77, 24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101, 72, 92, 95, 98, 112, 100, 103, 99
  };

  // Zigzag order built by walking the anti-diagonals, alternating direction
  task automatic build_zigzag();
    int n = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
          zz[n] = r * 8 + (s - r);
          n++;
        end
      end else begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
          zz[n] = r * 8 + (s - r);
          n++;
        end
      end
    end
  endtask

  function automatic int map_pos(input int p);
`ifdef Y_DEQUANT_ZIGZAG_EN
    return zz[p];
`else
    return p;
`endif
  endfunction

  task automatic model_accept(input int v);
    exp_t e;
    int   p;
    e.idx  = map_pos(tb_pos);
    p      = v * qtab[e.idx];
    e.sat  = 1'b0;
    if (p > 2047) begin
      p = 2047;
      e.sat = 1'b1;
    end else if (p < -2048) begin
      p = -2048;
      e.sat = 1'b1;
    end
    e.coef = p;
    e.last = (tb_pos == 63);
    exp_q.push_back(e);
    tb_pos = (tb_pos + 1) % 64;
  endtask

  task automatic model_flush();
    exp_q.delete();
    tb_pos = 0;
  endtask

  // One clock: drive inputs, sample outputs mid-cycle, then advance past the edge
  task automatic step(input bit v, input int c, input bit rdy, input bit clr,
                      output bit acc, output bit pop, output bit ov, output bit ir,
                      output int oc, output int oi, output bit ol, output bit os);
    in_valid  = v;
    in_coef   = c[IN_W-1:0];
    out_ready = rdy;
    clear     = clr;
    #1;
    ir  = in_ready;
    ov  = out_valid;
    oc  = int'(out_coef);
    oi  = int'(out_idx);
    ol  = out_last;
    os  = out_sat;
    acc = v && in_ready && !clr;
    pop = out_valid && rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_coef = '0; out_ready = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_coef !== 12'sd0 || out_idx !== 6'd0 ||
        out_last !== 1'b0 || out_sat !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_state got v=%0b c=%0d i=%0d l=%0b s=%0b rdy=%0b want all 0, rdy=1",
               out_valid, out_coef, out_idx, out_last, out_sat, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_flush();
  endtask

  task automatic test_raster_basic();
    bit acc, pop, ov, ir, ol, os;
    int oc, oi, n = 0;
    int vals[2]   = '{5, -3};
    int want_c[2] = '{80, -33};
    int want_i[2] = '{0, 1};
    exp_t e;
    for (int k = 0; k < 6; k++) begin
      step(k < 2, (k < 2) ? vals[k] : 0, 1'b1, 1'b0, acc, pop, ov, ir, oc, oi, ol, os);
      if (k < 2) begin
        checks++;
        if (ov !== 1'b0) begin
          errors++;
          $display("[TB] FAIL latency_early cycle=%0d got out_valid=%0b want 0", k, ov);
        end
      end
      if (pop) begin
        checks++;
        if (n > 1 || k !== n + 2 || oc !== want_c[n] || oi !== want_i[n]) begin
          errors++;
          $display("[TB] FAIL raster_basic cycle=%0d got c=%0d i=%0d want c=%0d i=%0d at cycle %0d",
                   k, oc, oi, want_c[n % 2], want_i[n % 2], n + 2);
        end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        n++;
      end
      if (acc) model_accept(vals[k]);
    end
    checks++;
    if (n !== 2) begin
      errors++;
      $display("[TB] FAIL raster_count got %0d outputs want 2", n);
    end
  endtask

  task automatic test_back_to_back();
    bit acc, pop, ov, ir, ol, os;
    int oc, oi, n_out = 0, n_last = 0;
    exp_t e;
    step(1'b0, 0, 1'b1, 1'b1, acc, pop, ov, ir, oc, oi, ol, os);
    model_flush();
    for (int k = 0; k < 70; k++) begin
      step(k < 65, 1, 1'b1, 1'b0, acc, pop, ov, ir, oc, oi, ol, os);
      if (pop) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL b2b_extra got c=%0d i=%0d want no output", oc, oi);
        end else begin
          e = exp_q.pop_front();
          if (oc !== e.coef || oi !== e.idx || ol !== e.last || os !== e.sat) begin
            errors++;
            $display("[TB] FAIL b2b_out n=%0d got c=%0d i=%0d l=%0b s=%0b want c=%0d i=%0d l=%0b s=%0b",
                     n_out, oc, oi, ol, os, e.coef, e.idx, e.last, e.sat);
          end
        end
        n_out++;
        if (ol) n_last++;
      end
      if (acc) model_accept(1);
    end
    checks++;
    if (n_out !== 65 || n_last !== 1 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_totals got outs=%0d lasts=%0d pending=%0d want 65 1 0",
               n_out, n_last, exp_q.size());
    end
  endtask

  task automatic test_saturation();
    bit acc, pop, ov, ir, ol, os;
    int oc, oi, v, n = 0;
    exp_t e;
    step(1'b0, 0, 1'b1, 1'b1, acc, pop, ov, ir, oc, oi, ol, os);
    model_flush();
    for (int k = 0; k < 135; k++) begin
      v = (k == 63) ? 1023 : (k == 127) ? -1024 : (k == 128) ? 20 : 0;
      step(k < 129, v, 1'b1, 1'b0, acc, pop, ov, ir, oc, oi, ol, os);
      if (pop) begin
        if (n == 63 || n == 127 || n == 128) begin
          checks++;
          if ((n == 63  && (oc !== 2047  || os !== 1'b1 || ol !== 1'b1)) ||
              (n == 127 && (oc !== -2048 || os !== 1'b1 || ol !== 1'b1)) ||
              (n == 128 && (oc !== 320   || os !== 1'b0 || oi !== map_pos(0)))) begin
            errors++;
            $display("[TB] FAIL sat_corner n=%0d got c=%0d s=%0b l=%0b i=%0d", n, oc, os, ol, oi);
          end
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL sat_extra got c=%0d want no output", oc);
        end else begin
          e = exp_q.pop_front();
          if (oc !== e.coef || oi !== e.idx || ol !== e.last || os !== e.sat) begin
            errors++;
            $display("[TB] FAIL sat_out n=%0d got c=%0d i=%0d l=%0b s=%0b want c=%0d i=%0d l=%0b s=%0b",
                     n, oc, oi, ol, os, e.coef, e.idx, e.last, e.sat);
          end
        end
        n++;
      end
      if (acc) model_accept(v);
    end
  endtask

  task automatic test_backpressure();
    bit acc, pop, ov, ir, ol, os;
    int oc, oi, sc, si, nxt;
    int vals[4] = '{3, 4, 5, 6};
    exp_t e;
    step(1'b0, 0, 1'b1, 1'b1, acc, pop, ov, ir, oc, oi, ol, os);
    model_flush();
    nxt = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, vals[nxt], 1'b0, 1'b0, acc, pop, ov, ir, oc, oi, ol, os);
      if (k == 2) begin
        sc = oc;
        si = oi;
        checks++;
        if (exp_q.size() == 0 || sc !== exp_q[0].coef || si !== exp_q[0].idx) begin
          errors++;
          $display("[TB] FAIL bp_head got c=%0d i=%0d want first accepted output", sc, si);
        end
      end
      if (k >= 2) begin
        checks++;
        if (ov !== 1'b1 || ir !== 1'b0 || oc !== sc || oi !== si) begin
          errors++;
          $display("[TB] FAIL bp_hold k=%0d got v=%0b rdy=%0b c=%0d i=%0d want v=1 rdy=0 c=%0d i=%0d",
                   k, ov, ir, oc, oi, sc, si);
        end
      end
      if (acc) begin
        model_accept(vals[nxt]);
        nxt++;
      end
    end
    for (int k = 0; k < 10; k++) begin
      step(nxt < 4, (nxt < 4) ? vals[nxt] : 0, 1'b1, 1'b0, acc, pop, ov, ir, oc, oi, ol, os);
      if (pop) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL bp_dup got c=%0d want no output", oc);
        end else begin
          e = exp_q.pop_front();
          if (oc !== e.coef || oi !== e.idx) begin
            errors++;
            $display("[TB] FAIL bp_out got c=%0d i=%0d want c=%0d i=%0d", oc, oi, e.coef, e.idx);
          end
        end
      end
      if (acc) begin
        model_accept(vals[nxt]);
        nxt++;
      end
    end
    checks++;
    if (exp_q.size() != 0 || nxt !== 4) begin
      errors++;
      $display("[TB] FAIL bp_loss got pending=%0d sent=%0d want 0 4", exp_q.size(), nxt);
    end
  endtask

  // Flush mid-block via clear (use_reset=0) or async reset (use_reset=1)
  task automatic test_flush(input bit use_reset);
    bit acc, pop, ov, ir, ol, os;
    int oc, oi, v, n = 0;
    exp_t e;
    for (int k = 0; k < 10; k++) begin
      v = int'($urandom_range(0, 200)) - 100;
      step(1'b1, v, 1'b1, 1'b0, acc, pop, ov, ir, oc, oi, ol, os);
      if (acc) model_accept(v);
    end
    if (use_reset) begin
      in_valid = 1'b1;
      rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_coef !== 12'sd0 || out_idx !== 6'd0 ||
          out_last !== 1'b0 || out_sat !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_mid got v=%0b c=%0d i=%0d l=%0b s=%0b want all 0",
                 out_valid, out_coef, out_idx, out_last, out_sat);
      end
      @(posedge clk); #1;
      rst = 1'b1;
    end else begin
      step(1'b1, 9, 1'b1, 1'b1, acc, pop, ov, ir, oc, oi, ol, os);
    end
    model_flush();
    for (int k = 0; k < 5; k++) begin
      step(k == 0, 2, 1'b1, 1'b0, acc, pop, ov, ir, oc, oi, ol, os);
      if (k == 0) begin
        checks++;
        if (ov !== 1'b0 || oc !== 0 || oi !== 0 || ol !== 1'b0 || os !== 1'b0) begin
          errors++;
          $display("[TB] FAIL flush_state rst=%0b got v=%0b c=%0d i=%0d l=%0b s=%0b want all 0",
                   use_reset, ov, oc, oi, ol, os);
        end
      end
      if (pop) begin
        checks++;
        if (n > 0 || oc !== 32 || oi !== 0) begin
          errors++;
          $display("[TB] FAIL flush_restart rst=%0b got c=%0d i=%0d n=%0d want c=32 i=0 once",
                   use_reset, oc, oi, n);
        end
        n++;
      end
      if (acc) model_accept(2);
    end
    exp_q.delete();
  endtask

  task automatic test_zigzag();
`ifdef Y_DEQUANT_ZIGZAG_EN
    bit acc, pop, ov, ir, ol, os;
    int oc, oi, n = 0;
    int want_c[3] = '{16, 11, 12};
    int want_i[3] = '{0, 1, 8};
    step(1'b0, 0, 1'b1, 1'b1, acc, pop, ov, ir, oc, oi, ol, os);
    model_flush();
    for (int k = 0; k < 7; k++) begin
      step(k < 3, 1, 1'b1, 1'b0, acc, pop, ov, ir, oc, oi, ol, os);
      if (pop) begin
        checks++;
        if (n > 2 || oc !== want_c[n] || oi !== want_i[n]) begin
          errors++;
          $display("[TB] FAIL zigzag n=%0d got c=%0d i=%0d", n, oc, oi);
        end
        n++;
      end
    end
    checks++;
    if (n !== 3) begin
      errors++;
      $display("[TB] FAIL zigzag_count got %0d want 3", n);
    end
    model_flush();
`endif
  endtask

  task automatic test_random();
    bit acc, pop, ov, ir, ol, os, v, r, c;
    int oc, oi, val, n = 0;
    exp_t e;
    step(1'b0, 0, 1'b1, 1'b1, acc, pop, ov, ir, oc, oi, ol, os);
    model_flush();
    for (int k = 0; k < 400; k++) begin
      v   = (k < 390) && ($urandom_range(0, 3) != 0);
      r   = (k >= 390) || ($urandom_range(0, 3) != 0);
      c   = (k < 390) && ($urandom_range(0, 59) == 0);
      val = int'($urandom_range(0, 2047)) - 1024;
      step(v, val, r, c, acc, pop, ov, ir, oc, oi, ol, os);
      if (pop) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL rand_extra k=%0d got c=%0d want no output", k, oc);
        end else begin
          e = exp_q.pop_front();
          if (oc !== e.coef || oi !== e.idx || ol !== e.last || os !== e.sat) begin
            errors++;
            $display("[TB] FAIL rand_out k=%0d got c=%0d i=%0d l=%0b s=%0b want c=%0d i=%0d l=%0b s=%0b",
                     k, oc, oi, ol, os, e.coef, e.idx, e.last, e.sat);
          end
        end
        n++;
      end
      if (c) model_flush();
      else if (acc) model_accept(val);
    end
    checks++;
    if (exp_q.size() != 0 || n == 0) begin
      errors++;
      $display("[TB] FAIL rand_drain got pending=%0d outs=%0d want 0 pending", exp_q.size(), n);
    end
  endtask

  initial begin
    build_zigzag();
    test_reset();
    test_raster_basic();
    test_back_to_back();
    test_saturation();
    test_backpressure();
    test_flush(1'b0);
    test_flush(1'b1);
    test_zigzag();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
